// File: rtl/cnn_result_voter.sv
// cnn_result_voter: sliding-window majority vote over CNN class results with a hysteretic fault alarm.
// Define VOTER_STATS_EN to count HEALTHY->FAULT transitions on fault_events.
module cnn_result_voter #(
    parameter int CLASS_W       = 4,
    parameter int NUM_CLASSES   = 10,
    parameter int WIN           = 8,
    parameter int HEALTHY_CLASS = 0,
    parameter int ALARM_CNT     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [CLASS_W-1:0] class_in,
    input  logic               class_valid,
    output logic [CLASS_W-1:0] vote_class,
    output logic               vote_valid,
    output logic               fault_alarm,
    output logic [7:0]         invalid_cnt,
    output logic [7:0]         fault_events
);
    localparam int CW = $clog2(WIN + 1);

    typedef enum logic {HEALTHY, FAULT} state_t;

    state_t             state;
    logic [CLASS_W-1:0] hist [WIN];
    logic [CW-1:0]      cnt [NUM_CLASSES];
    logic [CW-1:0]      cnt_nx [NUM_CLASSES];
    logic [CW-1:0]      fill, fill_nx, best_cnt;
    logic [CLASS_W-1:0] best;
    logic [3:0]         streak;
    logic               accept, full, deviate, trip;

    assign full    = fill == CW'(WIN);
    assign accept  = class_valid && int'(class_in) < NUM_CLASSES;
    assign fill_nx = full ? fill : fill + CW'(1);
    assign deviate = (vote_class != CLASS_W'(HEALTHY_CLASS)) == (state == HEALTHY);
    assign trip    = vote_valid && deviate && streak == 4'(ALARM_CNT - 1);

    // Strict '>' while scanning upward keeps ties on the lowest class index.
    always_comb begin
        best     = '0;
        best_cnt = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            cnt_nx[c] = cnt[c] + CW'(accept && int'(class_in) == c)
                               - CW'(accept && full && int'(hist[WIN-1]) == c);
            if (cnt_nx[c] > best_cnt) begin
                best     = CLASS_W'(c);
                best_cnt = cnt_nx[c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            foreach (hist[i]) hist[i] <= '0;
            foreach (cnt[c]) cnt[c] <= '0;
            fill        <= '0;
            vote_class  <= CLASS_W'(HEALTHY_CLASS);
            vote_valid  <= 1'b0;
            invalid_cnt <= '0;
        end else if (clear) begin
            foreach (hist[i]) hist[i] <= '0;
            foreach (cnt[c]) cnt[c] <= '0;
            fill        <= '0;
            vote_class  <= CLASS_W'(HEALTHY_CLASS);
            vote_valid  <= 1'b0;
            invalid_cnt <= '0;
        end else begin
            vote_valid <= accept && fill_nx == CW'(WIN);
            if (accept) begin
                hist[0] <= class_in;
                for (int i = 1; i < WIN; i++) hist[i] <= hist[i-1];
                foreach (cnt[c]) cnt[c] <= cnt_nx[c];
                fill <= fill_nx;
                if (fill_nx == CW'(WIN)) vote_class <= best;
            end else if (class_valid && invalid_cnt != 8'hFF) begin
                invalid_cnt <= invalid_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HEALTHY;
            streak      <= '0;
            fault_alarm <= 1'b0;
        end else if (clear) begin
            state       <= HEALTHY;
            streak      <= '0;
            fault_alarm <= 1'b0;
        end else if (vote_valid) begin
            if (trip) begin
                state       <= state == HEALTHY ? FAULT : HEALTHY;
                fault_alarm <= state == HEALTHY;
                streak      <= '0;
            end else begin
                streak <= deviate ? streak + 4'd1 : 4'd0;
            end
        end
    end

`ifdef VOTER_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            fault_events <= '0;
        else if (clear)
            fault_events <= '0;
        else if (trip && state == HEALTHY && fault_events != 8'hFF)
            fault_events <= fault_events + 8'd1;
    end
`else
    assign fault_events = 8'd0;
`endif

endmodule

// File: tb/tb_cnn_result_voter.sv
// tb_cnn_result_voter: directed scoreboard bench for cnn_result_voter (WIN=8, ALARM_CNT=3).
module tb_cnn_result_voter;
    logic       clk = 0, reset = 0, clear = 0, class_valid = 0;
    logic [3:0] class_in = 0;
    logic [3:0] vote_class;
    logic       vote_valid, fault_alarm;
    logic [7:0] invalid_cnt, fault_events;

    int   n_cmp = 0, n_err = 0;
    int   mh[$];
    int   exp_q[$];
    int   v, m_streak = 0, m_events = 0;
    logic m_alarm = 0;
    int   pre[8] = '{4, 0, 4, 4, 4, 4, 0, 0};

    cnn_result_voter dut (
        .clk(clk), .reset(reset), .clear(clear), .class_in(class_in), .class_valid(class_valid),
        .vote_class(vote_class), .vote_valid(vote_valid), .fault_alarm(fault_alarm),
        .invalid_cnt(invalid_cnt), .fault_events(fault_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int argmax();
        int c[10];
        int b = 0;
        foreach (c[k]) c[k] = 0;
        foreach (mh[i]) c[mh[i]]++;
        for (int k = 1; k < 10; k++) if (c[k] > c[b]) b = k;
        return b;
    endfunction

    task automatic model_reset();
        mh.delete();
        exp_q.delete();
        m_alarm  = 0;
        m_streak = 0;
        m_events = 0;
    endtask

    task automatic send(input int c);
        class_in    = 4'(c);
        class_valid = 1;
        if (c < 10) begin
            mh.push_back(c);
            if (mh.size() > 8) mh.delete(0);
            if (mh.size() == 8) exp_q.push_back(argmax());
        end
        @(posedge clk);
        #1 class_valid = 0;
    endtask

    task automatic idle(input int n);
        class_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1;
        @(posedge clk);
        #1 clear = 0;
        model_reset();
    endtask

    // Scoreboard: alarm compared before this cycle's vote updates the alarm model.
    always @(negedge clk) begin
        if (reset) begin
            chk("alarm", fault_alarm, m_alarm);
            if (vote_valid) begin
                if (exp_q.size() == 0) chk("unexpected_vote", vote_valid, 0);
                else begin
                    v = exp_q.pop_front();
                    chk("vote", vote_class, v);
                    if (!m_alarm) begin
                        m_streak = (v != 0) ? m_streak + 1 : 0;
                        if (m_streak == 3) begin m_alarm = 1; m_streak = 0; m_events++; end
                    end else begin
                        m_streak = (v == 0) ? m_streak + 1 : 0;
                        if (m_streak == 3) begin m_alarm = 0; m_streak = 0; end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vote_class", vote_class, 0);
        chk("rst_vote_valid", vote_valid, 0);
        chk("rst_alarm", fault_alarm, 0);
        chk("rst_invalid", invalid_cnt, 0);
        chk("rst_events", fault_events, 0);
        reset = 1;

        for (int i = 0; i < 8; i++) send(3);
        chk("first_vote_valid", vote_valid, 1);
        chk("first_vote_class", vote_class, 3);
        idle(2);
        chk("first_drained", exp_q.size(), 0);
        do_clear();
        chk("clear_vote_class", vote_class, 0);

        for (int i = 0; i < 8; i++) send(0);
        for (int i = 0; i < 3; i++) send(5);
        idle(2);
        chk("cnt0", dut.cnt[0], 5);
        chk("cnt5", dut.cnt[5], 3);
        chk("no_alarm", fault_alarm, 0);

        do_clear();
        for (int i = 0; i < 4; i++) send(2);
        for (int i = 0; i < 4; i++) send(6);
        idle(2);
        chk("tie_vote", vote_class, 2);

        do_clear();
        for (int i = 0; i < 10; i++) send(4);
        chk("alarm_pre", fault_alarm, 0);
        idle(1);
        chk("alarm_set", fault_alarm, 1);
        foreach (pre[i]) send(pre[i]);
        send(0); send(4); send(0); send(0);
        chk("alarm_hold", fault_alarm, 1);
        send(0);
        chk("alarm_hold_last", fault_alarm, 1);
        idle(1);
        chk("alarm_clear", fault_alarm, 0);
`ifdef VOTER_STATS_EN
        chk("fault_events", fault_events, m_events);
        chk("fault_events_one", fault_events, 1);
`else
        chk("fault_events", fault_events, 0);
`endif

        for (int i = 0; i < 300; i++) send(12);
        idle(2);
        chk("invalid_sat", invalid_cnt, 255);
        send(0);
        idle(2);
        chk("post_invalid_drained", exp_q.size(), 0);

        do_clear();
        for (int i = 0; i < 3; i++) send(1);
        clear = 1; class_in = 4'd7; class_valid = 1;
        @(posedge clk);
        #1 clear = 0; class_valid = 0;
        model_reset();
        chk("clr_fill", dut.fill, 0);
        chk("clr_cnt7", dut.cnt[7], 0);
        chk("clr_cnt1", dut.cnt[1], 0);
        for (int i = 0; i < 7; i++) send(1);
        idle(2);
        send(1);
        chk("clr_vote_valid", vote_valid, 1);
        chk("clr_vote_class", vote_class, 1);

        send(12);
        idle(1);
        chk("pre_rst_invalid", invalid_cnt, 1);
        #2 reset = 0;
        #1;
        chk("async_vote_class", vote_class, 0);
        chk("async_invalid", invalid_cnt, 0);
        chk("async_vote_valid", vote_valid, 0);
        chk("async_alarm", fault_alarm, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1;
        idle(2);
        chk("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
